// File: rtl/sensor_scheduler.sv
// Frame-based sensor slot scheduler: a 1 us tick builds a frame period, and each
// frame walks the enabled slots in order, starting each one and waiting for DONE or a timeout.
module sensor_scheduler #(
  parameter int PRESCALE   = 26,
  parameter int PERIOD_US  = 1000,
  parameter int TIMEOUT_US = 200
) (
  input  logic       CLK_26MHZ_IN,
  input  logic       RESET,
  input  logic [3:0] ENABLE_MASK,
  input  logic [3:0] DONE,
  input  logic       CLEAR_FLAGS,
  output logic [3:0] START,
  output logic [1:0] SLOT_IDX,
  output logic       BUSY,
  output logic       FRAME_PULSE,
  output logic [3:0] TIMEOUT_FLAGS,
  output logic       OVERRUN
);

  // state   | meaning
  // S_IDLE  | waiting for frame start
  // S_SEL   | scan active mask from slot_q upward
  // S_START | one-cycle start pulse for slot_q, timeout counter cleared
  // S_WAIT  | waiting for DONE[slot_q] or timeout
  typedef enum logic [1:0] {S_IDLE, S_SEL, S_START, S_WAIT} state_t;

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FC_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int TO_W = $clog2(TIMEOUT_US + 1);

  state_t          state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [3:0]      mask_q, mask_d;
  logic [PS_W-1:0] ps_cnt;
  logic [FC_W-1:0] frame_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            tick;
  logic            frame_start;
  logic            to_expire;
  logic            to_clear;
  logic            slot_timeout;
  logic [3:0]      flag_set;

  assign tick        = (ps_cnt == PS_W'(PRESCALE - 1));
  assign frame_start = tick && (frame_cnt == FC_W'(PERIOD_US - 1));
  // Expiry is the tick that would carry the counter up to TIMEOUT_US.
  assign to_expire   = tick && (to_cnt == TO_W'(TIMEOUT_US - 1));
  assign flag_set    = slot_timeout ? (4'b0001 << slot_q) : 4'b0000;

  always_ff @(posedge CLK_26MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      ps_cnt      <= '0;
      frame_cnt   <= '0;
      FRAME_PULSE <= 1'b0;
    end else begin
      ps_cnt      <= tick ? '0 : ps_cnt + PS_W'(1);
      FRAME_PULSE <= frame_start;
      if (tick) frame_cnt <= frame_start ? '0 : frame_cnt + FC_W'(1);
    end
  end

  always_ff @(posedge CLK_26MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      slot_q  <= 2'd0;
      mask_q  <= 4'b0000;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      if (to_clear) to_cnt <= '0;
      else if (state_q == S_WAIT && tick) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    mask_d       = mask_q;
    to_clear     = 1'b0;
    slot_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          mask_d  = ENABLE_MASK;
          slot_d  = 2'd0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (mask_q[slot_q]) state_d = S_START;
        else if (slot_q == 2'd3) state_d = S_IDLE;
        else slot_d = slot_q + 2'd1;
      end
      S_START: begin
        to_clear = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // DONE beats a simultaneous expiry, so the flag only sets without DONE.
        if (DONE[slot_q] || to_expire) begin
          slot_timeout = !DONE[slot_q];
          if (slot_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            slot_d  = slot_q + 2'd1;
            state_d = S_SEL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Set events win over a same-cycle clear.
  always_ff @(posedge CLK_26MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      TIMEOUT_FLAGS <= 4'b0000;
      OVERRUN       <= 1'b0;
    end else begin
      TIMEOUT_FLAGS <= (CLEAR_FLAGS ? 4'b0000 : TIMEOUT_FLAGS) | flag_set;
      OVERRUN       <= (CLEAR_FLAGS ? 1'b0 : OVERRUN) | (frame_start && state_q != S_IDLE);
    end
  end

  assign START    = (state_q == S_START) ? (4'b0001 << slot_q) : 4'b0000;
  assign SLOT_IDX = slot_q;
  assign BUSY     = (state_q != S_IDLE);

endmodule
